// File: rtl/phrase_pkg.sv
// phrase_pkg: shared types, widths and note-word helpers for the phrase player
package phrase_pkg;
  localparam logic [3:0] NOTE_REST = 4'h7;
  localparam int ENTRY_W = 32;
  localparam int LEN_W = 8;
  localparam int NCNT_W = 3;
  localparam int ADDR_W = 4;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;
  function automatic logic [3:0] nibble(input logic [ENTRY_W-1:0] e, input logic [NCNT_W-1:0] k);
    logic [ENTRY_W-1:0] s;
    s = e << {k, 2'b00};
    return s[ENTRY_W-1 -: 4];
  endfunction
  function automatic logic len_bit(input logic [LEN_W-1:0] l, input logic [NCNT_W-1:0] k);
    logic [LEN_W-1:0] s;
    s = l << k;
    return s[LEN_W-1];
  endfunction
endpackage

// File: rtl/phrase_note_timer.sv
// phrase_note_timer: loadable tick down-counter; expire flags the last tick of a note
module phrase_note_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic       expire
);
  logic [3:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt > 4'd1) cnt <= cnt - 4'd1;
  end
  assign expire = cnt <= 4'd1;
endmodule

// File: rtl/phrase_player.sv
// phrase_player: plays one ROM phrase note by note on rhythm ticks; PHRASE_PLAYER_LOOP_EN restarts it endlessly
module phrase_player
  import phrase_pkg::*;
#(
  parameter int LONG_TICKS  = 2,
  parameter int SHORT_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        phrase_sel,
  input  logic              tick,
  output logic [ADDR_W-1:0] db_addr,
  input  logic [ENTRY_W-1:0] db_entry,
  input  logic [LEN_W-1:0]  length_entry,
  input  logic [NCNT_W-1:0] n_note,
  output logic [3:0]        note_code,
  output logic              note_on,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [ENTRY_W-1:0] entry;
  logic [LEN_W-1:0] len;
  logic [NCNT_W-1:0] last, idx, idx_n;
  logic expire, adv, fin, load_tmr;
  logic [3:0] load_val;
  function automatic logic [3:0] dur(input logic b);
    return b ? 4'(LONG_TICKS) : 4'(SHORT_TICKS);
  endfunction
  assign idx_n = idx + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    adv = 1'b0;
    fin = 1'b0;
    if (stop) state_n = IDLE;
    else case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = PLAY;
      PLAY: if (tick && expire) begin
        if (idx == last) begin
          fin = 1'b1;
`ifdef PHRASE_PLAYER_LOOP_EN
          state_n = LOAD;
`else
          state_n = DONE;
`endif
        end else adv = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign load_tmr = (state == LOAD && !stop) || adv;
  assign load_val = state == LOAD ? dur(length_entry[LEN_W-1]) : dur(len_bit(len, idx_n));
  phrase_note_timer u_timer (
    .clk(clk),
    .rst(rst),
    .load(load_tmr),
    .load_val(load_val),
    .tick(tick && state == PLAY),
    .expire(expire)
  );
  // ROM outputs are only trusted during LOAD; PLAY runs entirely from the shadow copy
  always_ff @(posedge clk) begin
    if (rst) begin
      db_addr <= '0;
      note_code <= NOTE_REST;
      note_strobe <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      entry <= '0;
      len <= '0;
      last <= '0;
    end else begin
      note_strobe <= 1'b0;
      done <= 1'b0;
      if (stop) note_code <= NOTE_REST;
      else case (state)
        IDLE: if (start) db_addr <= phrase_sel;
        LOAD: begin
          entry <= db_entry;
          len <= length_entry;
          last <= n_note;
          idx <= '0;
          note_code <= nibble(db_entry, '0);
          note_strobe <= 1'b1;
        end
        PLAY: if (fin) begin
          done <= 1'b1;
          note_code <= NOTE_REST;
        end else if (adv) begin
          idx <= idx_n;
          note_code <= nibble(entry, idx_n);
          note_strobe <= 1'b1;
        end
        default: note_code <= NOTE_REST;
      endcase
    end
  end
  assign note_on = state == PLAY && note_code != NOTE_REST;
  assign busy = state != IDLE;
endmodule
